// File: rtl/seq_gen_sync_pkg.sv
// seq_gen_sync shared types and constants.
// State encoding, register offsets and version id.
package seq_gen_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int REG_RST    = 0;
    localparam int REG_START  = 1;
    localparam int REG_CONF   = 2;
    localparam int REG_SIZE   = 3;
    localparam int REG_GAP    = 5;
    localparam int REG_REPEAT = 7;
    localparam int MEM_OFFSET = 16;

    localparam logic [7:0] VERSION = 8'd1;

endpackage

// File: rtl/bus_to_ip.sv
// Bus decoder: maps the shared 8-bit bus window onto local IP strobes.
// Ports: BUS_* host side, IP_* block side (IP_ADD relative to BASEADDR).
module bus_to_ip #(
    parameter int BASEADDR  = 0,
    parameter int HIGHADDR  = 0,
    parameter int ABUSWIDTH = 16,
    parameter int DBUSWIDTH = 8
) (
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [DBUSWIDTH-1:0] BUS_DATA,
    output logic                 IP_RD,
    output logic                 IP_WR,
    output logic [ABUSWIDTH-1:0] IP_ADD,
    output logic [DBUSWIDTH-1:0] IP_DATA_IN,
    input  logic [DBUSWIDTH-1:0] IP_DATA_OUT
);
    localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);
    localparam logic [ABUSWIDTH-1:0] SPAN = ABUSWIDTH'(HIGHADDR - BASEADDR);

    logic [ABUSWIDTH-1:0] offset;
    logic                 cs;

    // Wrapping subtraction: addresses below BASE become large and miss.
    assign offset     = BUS_ADD - BASE;
    assign cs         = (offset <= SPAN);
    assign IP_ADD     = cs ? offset : '0;
    assign IP_RD      = cs & BUS_RD;
    assign IP_WR      = cs & BUS_WR;
    assign IP_DATA_IN = BUS_DATA;
    assign BUS_DATA   = (cs && BUS_RD) ? IP_DATA_OUT : {DBUSWIDTH{1'bz}};

endmodule

// File: rtl/seq_gen_sync_core.sv
// Pattern generator core: registers, start sync, playback FSM, pattern RAM.
// Ports: clk/rst, ip_* local bus, ext_start, seq_out/seq_active playback.
module seq_gen_sync_core #(
    parameter int ABUSWIDTH = 16,
    parameter int MEM_BYTES = 8 * 1024,
    parameter int OUT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ABUSWIDTH-1:0] ip_add,
    input  logic                 ip_rd,
    input  logic                 ip_wr,
    input  logic [7:0]           ip_din,
    output logic [7:0]           ip_dout,
    input  logic                 ext_start,
    output logic [OUT_BITS-1:0]  seq_out,
    output logic                 seq_active
);
    import seq_gen_sync_pkg::*;

    localparam int W     = OUT_BITS / 8;
    localparam int DEPTH = MEM_BYTES / W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (W > 1) ? $clog2(W) : 1;

    localparam logic [ABUSWIDTH-1:0] A_RST    = ABUSWIDTH'(REG_RST);
    localparam logic [ABUSWIDTH-1:0] A_START  = ABUSWIDTH'(REG_START);
    localparam logic [ABUSWIDTH-1:0] A_CONF   = ABUSWIDTH'(REG_CONF);
    localparam logic [ABUSWIDTH-1:0] A_SIZE_L = ABUSWIDTH'(REG_SIZE);
    localparam logic [ABUSWIDTH-1:0] A_SIZE_H = ABUSWIDTH'(REG_SIZE + 1);
    localparam logic [ABUSWIDTH-1:0] A_GAP_L  = ABUSWIDTH'(REG_GAP);
    localparam logic [ABUSWIDTH-1:0] A_GAP_H  = ABUSWIDTH'(REG_GAP + 1);
    localparam logic [ABUSWIDTH-1:0] A_REP    = ABUSWIDTH'(REG_REPEAT);
    localparam logic [ABUSWIDTH-1:0] A_MEM    = ABUSWIDTH'(MEM_OFFSET);

    logic soft_rst, rst_all;
    assign soft_rst = ip_wr && (ip_add == A_RST);
    assign rst_all  = rst || soft_rst;

    // Configuration registers
    logic        conf_q, conf_d;
    logic [15:0] size_q, size_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  repeat_q, repeat_d;

    // Start path
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       rise_q, rise_d;
    logic       start_q, start_d;

    // Playback state
    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      pass_q, pass_d;
    logic [15:0]     gap_cnt_q, gap_cnt_d;
    logic [16:0]     lat_size_q, lat_size_d;
    logic [15:0]     lat_gap_q, lat_gap_d;
    logic [7:0]      lat_rep_q, lat_rep_d;
    logic            active_q, active_d;

    // Bus read path
    logic [7:0]    reg_rd_q, reg_rd_d;
    logic          rd_sel_q, rd_sel_d;
    logic [LW-1:0] rd_lane_q, rd_lane_d;

    // Memory addressing from the bus side
    logic [ABUSWIDTH-1:0] mem_byte;
    logic [31:0]          mem_byte32;
    logic                 mem_hit;
    logic [AW-1:0]        bus_word;
    logic [LW-1:0]        bus_lane;

    assign mem_byte   = ip_add - A_MEM;
    assign mem_byte32 = 32'(mem_byte);
    assign mem_hit    = (ip_add >= A_MEM) && (mem_byte32 < 32'(MEM_BYTES));
    assign bus_word   = AW'(mem_byte32 / W);
    assign bus_lane   = LW'(mem_byte32 % W);

    logic [16:0] size_eff;
    logic        last_word;
    logic        start_wr;

    assign size_eff  = ({1'b0, size_q} > 17'(DEPTH)) ? 17'(DEPTH)
                                                     : {1'b0, size_q};
    assign last_word = (17'(addr_q) == (lat_size_q - 17'd1));
    assign start_wr  = ip_wr && (ip_add == A_START) && ip_din[0];

    always_comb begin
        conf_d   = conf_q;
        size_d   = size_q;
        gap_d    = gap_q;
        repeat_d = repeat_q;
        if (ip_wr) begin
            unique case (1'b1)
                ip_add == A_CONF:   conf_d        = ip_din[0];
                ip_add == A_SIZE_L: size_d[7:0]   = ip_din;
                ip_add == A_SIZE_H: size_d[15:8]  = ip_din;
                ip_add == A_GAP_L:  gap_d[7:0]    = ip_din;
                ip_add == A_GAP_H:  gap_d[15:8]   = ip_din;
                ip_add == A_REP:    repeat_d      = ip_din;
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer, then a registered rising-edge pulse.
    always_comb begin
        sync_d  = {sync_q[0], ext_start};
        prev_d  = sync_q[1];
        rise_d  = sync_q[1] & ~prev_q;
        start_d = start_wr || (conf_q && rise_q);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        gap_cnt_d  = gap_cnt_q;
        lat_size_d = lat_size_q;
        lat_gap_d  = lat_gap_q;
        lat_rep_d  = lat_rep_q;
        unique case (state_q)
            IDLE: begin
                if (start_q && (size_eff != 17'd0)) begin
                    state_d    = RUN;
                    addr_d     = '0;
                    pass_d     = 8'd1;
                    lat_size_d = size_eff;
                    lat_gap_d  = gap_q;
                    lat_rep_d  = repeat_q;
                end
            end
            RUN: begin
                if (!last_word) begin
                    addr_d = addr_q + AW'(1);
                end else if ((lat_rep_q != 8'd0) && (pass_q == lat_rep_q)) begin
                    state_d = IDLE;
                end else begin
                    if (pass_q != 8'hff) pass_d = pass_q + 8'd1;
                    addr_d = '0;
                    if (lat_gap_q != 16'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = lat_gap_q - 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 16'd0) state_d = RUN;
                else gap_cnt_d = gap_cnt_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Activity follows the state by one cycle to line up with the RAM read.
    assign active_d = (state_q != IDLE);

    always_comb begin
        reg_rd_d  = reg_rd_q;
        rd_sel_d  = rd_sel_q;
        rd_lane_d = rd_lane_q;
        if (ip_rd) begin
            rd_sel_d  = mem_hit;
            rd_lane_d = bus_lane;
            unique case (1'b1)
                ip_add == A_RST:    reg_rd_d = VERSION;
                ip_add == A_START:  reg_rd_d = {7'd0, state_q == IDLE};
                ip_add == A_CONF:   reg_rd_d = {7'd0, conf_q};
                ip_add == A_SIZE_L: reg_rd_d = size_q[7:0];
                ip_add == A_SIZE_H: reg_rd_d = size_q[15:8];
                ip_add == A_GAP_L:  reg_rd_d = gap_q[7:0];
                ip_add == A_GAP_H:  reg_rd_d = gap_q[15:8];
                ip_add == A_REP:    reg_rd_d = repeat_q;
                default:            reg_rd_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            conf_q     <= 1'b0;
            size_q     <= '0;
            gap_q      <= '0;
            repeat_q   <= 8'd1;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_q     <= 1'b0;
            start_q    <= 1'b0;
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            gap_cnt_q  <= '0;
            lat_size_q <= '0;
            lat_gap_q  <= '0;
            lat_rep_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            conf_q     <= conf_d;
            size_q     <= size_d;
            gap_q      <= gap_d;
            repeat_q   <= repeat_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            rise_q     <= rise_d;
            start_q    <= start_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            gap_cnt_q  <= gap_cnt_d;
            lat_size_q <= lat_size_d;
            lat_gap_q  <= lat_gap_d;
            lat_rep_q  <= lat_rep_d;
            active_q   <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rd_q  <= '0;
            rd_sel_q  <= 1'b0;
            rd_lane_q <= '0;
        end else begin
            reg_rd_q  <= reg_rd_d;
            rd_sel_q  <= rd_sel_d;
            rd_lane_q <= rd_lane_d;
        end
    end

    // Byte-lane RAMs: byte-wide bus port, word-wide playback port.
    // Playback read holds its value outside RUN so GAP repeats the last word.
    logic [OUT_BITS-1:0] play_word;
    logic [7:0]          lane_bus_rd [W];

    for (genvar l = 0; l < W; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] play_q;
        logic [7:0] bus_q;

        always_ff @(posedge clk) begin
            if (ip_wr && mem_hit && (bus_lane == LW'(l)))
                mem[bus_word] <= ip_din;
            if (state_q == RUN)
                play_q <= mem[addr_q];
            bus_q <= mem[bus_word];
        end

        assign play_word[l*8 +: 8] = play_q;
        assign lane_bus_rd[l]      = bus_q;
    end

    logic [7:0] mem_rd_byte;
    always_comb begin
        mem_rd_byte = 8'h00;
        for (int l = 0; l < W; l++)
            if (rd_lane_q == LW'(l)) mem_rd_byte = lane_bus_rd[l];
    end

    assign ip_dout    = rd_sel_q ? mem_rd_byte : reg_rd_q;
    assign seq_out    = active_q ? play_word : '0;
    assign seq_active = active_q;

endmodule

// File: rtl/seq_gen_sync.sv
// Bus-programmable pattern generator top: bus decoder plus playback core.
// Ports: BUS_* SiLab 8-bit bus, SEQ_EXT_START, SEQ_OUT, SEQ_ACTIVE.
module seq_gen_sync #(
    parameter int BASEADDR  = 0,
    parameter int HIGHADDR  = 0,
    parameter int ABUSWIDTH = 16,
    parameter int MEM_BYTES = 8 * 1024,
    parameter int OUT_BITS  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 SEQ_EXT_START,
    output logic [OUT_BITS-1:0]  SEQ_OUT,
    output logic                 SEQ_ACTIVE
);
    logic                 ip_rd, ip_wr;
    logic [ABUSWIDTH-1:0] ip_add;
    logic [7:0]           ip_din, ip_dout;

    bus_to_ip #(
        .BASEADDR  (BASEADDR),
        .HIGHADDR  (HIGHADDR),
        .ABUSWIDTH (ABUSWIDTH),
        .DBUSWIDTH (8)
    ) u_bus (
        .BUS_RD      (BUS_RD),
        .BUS_WR      (BUS_WR),
        .BUS_ADD     (BUS_ADD),
        .BUS_DATA    (BUS_DATA),
        .IP_RD       (ip_rd),
        .IP_WR       (ip_wr),
        .IP_ADD      (ip_add),
        .IP_DATA_IN  (ip_din),
        .IP_DATA_OUT (ip_dout)
    );

    seq_gen_sync_core #(
        .ABUSWIDTH (ABUSWIDTH),
        .MEM_BYTES (MEM_BYTES),
        .OUT_BITS  (OUT_BITS)
    ) u_core (
        .clk        (BUS_CLK),
        .rst        (BUS_RST),
        .ip_add     (ip_add),
        .ip_rd      (ip_rd),
        .ip_wr      (ip_wr),
        .ip_din     (ip_din),
        .ip_dout    (ip_dout),
        .ext_start  (SEQ_EXT_START),
        .seq_out    (SEQ_OUT),
        .seq_active (SEQ_ACTIVE)
    );

endmodule

// File: tb/tb_seq_gen_sync.sv
// Self-checking bench for seq_gen_sync (16-bit words, 32-word memory).
// Register table plus scoreboarded playback sequences.
module tb_seq_gen_sync;
    localparam int BASE  = 16'h4000;
    localparam int MEMB  = 64;
    localparam int OB    = 16;
    localparam int DEPTH = MEMB / (OB / 8);
    localparam int HIGH  = BASE + 16 + MEMB - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   bus_add = '0;
    wire  [7:0]    bus_data;
    logic          bus_rd = 1'b0;
    logic          bus_wr = 1'b0;
    logic          ext = 1'b0;
    logic [OB-1:0] seq_out;
    logic          seq_active;
    logic          drv_en = 1'b0;
    logic [7:0]    drv_data = '0;

    assign bus_data = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    seq_gen_sync #(
        .BASEADDR  (BASE),
        .HIGHADDR  (HIGH),
        .ABUSWIDTH (16),
        .MEM_BYTES (MEMB),
        .OUT_BITS  (OB)
    ) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .BUS_ADD       (bus_add),
        .BUS_DATA      (bus_data),
        .BUS_RD        (bus_rd),
        .BUS_WR        (bus_wr),
        .SEQ_EXT_START (ext),
        .SEQ_OUT       (seq_out),
        .SEQ_ACTIVE    (seq_active)
    );

    typedef struct {
        logic       wr;
        int         off;
        logic [7:0] data;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        act;
    } exp_t;

    vec_t        vt[$];
    exp_t        sb[$];
    logic [15:0] model_mem [DEPTH];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic bus_write(input int off, input logic [7:0] d);
        bus_add  = 16'(BASE + off);
        drv_data = d;
        drv_en   = 1'b1;
        bus_wr   = 1'b1;
        @(negedge clk);
        bus_wr   = 1'b0;
        drv_en   = 1'b0;
    endtask

    task automatic bus_read(input int off, output logic [7:0] d);
        bus_add = 16'(BASE + off);
        bus_rd  = 1'b1;
        @(negedge clk);
        d = bus_data;
        @(negedge clk);
        bus_rd = 1'b0;
    endtask

    task automatic read_check(input string name, input int off,
                              input logic [7:0] exp);
        logic [7:0] d;
        bus_read(off, d);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic mem_write_word(input int k, input logic [15:0] w);
        bus_write(16 + 2 * k, w[7:0]);
        bus_write(16 + 2 * k + 1, w[15:8]);
        model_mem[k] = w;
    endtask

    task automatic set_cfg(input int size, input int gap, input int rep);
        bus_write(3, 8'(size));
        bus_write(4, 8'(size >> 8));
        bus_write(5, 8'(gap));
        bus_write(6, 8'(gap >> 8));
        bus_write(7, 8'(rep));
    endtask

    task automatic add_vec(input logic wr, input int off, input logic [7:0] d);
        vec_t v;
        v.wr   = wr;
        v.off  = off;
        v.data = d;
        vt.push_back(v);
    endtask

    task automatic push_exp(input logic [15:0] o, input logic a);
        exp_t e;
        e.out = o;
        e.act = a;
        sb.push_back(e);
    endtask

    // Expected per-cycle output starting the cycle after the start edge.
    task automatic push_play(input int n, input int gap, input int passes,
                             input int tail);
        push_exp(16'h0, 1'b0);
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) push_exp(model_mem[k], 1'b1);
            if (p != passes - 1)
                for (int g = 0; g < gap; g++) push_exp(model_mem[n-1], 1'b1);
        end
        for (int t = 0; t < tail; t++) push_exp(16'h0, 1'b0);
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            check($sformatf("%s_out_c%0d", name, cyc), {16'd0, seq_out},
                  {16'd0, e.out});
            check($sformatf("%s_act_c%0d", name, cyc), {31'd0, seq_active},
                  {31'd0, e.act});
            cyc++;
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model_mem[k] = 16'h0;

        add_vec(0, 0, 8'h01);
        add_vec(0, 1, 8'h01);
        add_vec(0, 2, 8'h00);
        add_vec(0, 3, 8'h00);
        add_vec(0, 5, 8'h00);
        add_vec(0, 7, 8'h01);
        add_vec(0, 9, 8'h00);
        add_vec(0, 15, 8'h00);
        add_vec(1, 2, 8'h01);
        add_vec(0, 2, 8'h01);
        add_vec(1, 3, 8'h34);
        add_vec(1, 4, 8'h12);
        add_vec(0, 3, 8'h34);
        add_vec(0, 4, 8'h12);
        add_vec(1, 6, 8'hab);
        add_vec(0, 6, 8'hab);
        add_vec(1, 7, 8'h05);
        add_vec(0, 7, 8'h05);
        add_vec(1, 16, 8'h34);
        add_vec(1, 17, 8'h12);
        add_vec(0, 16, 8'h34);
        add_vec(0, 17, 8'h12);
        add_vec(1, 0, 8'h00);
        add_vec(0, 2, 8'h00);
        add_vec(0, 3, 8'h00);
        add_vec(0, 6, 8'h00);
        add_vec(0, 7, 8'h01);
        add_vec(0, 16, 8'h34);
        add_vec(0, 1, 8'h01);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_seq_out", {16'd0, seq_out}, 32'd0);
        check("rst_seq_active", {31'd0, seq_active}, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) bus_write(vt[i].off, vt[i].data);
            else read_check($sformatf("vec%0d_off%0d", i, vt[i].off),
                            vt[i].off, vt[i].data);
        end
        model_mem[0] = 16'h1234;

        // Single pass of three words.
        mem_write_word(0, 16'h0011);
        mem_write_word(1, 16'h0022);
        mem_write_word(2, 16'h0033);
        set_cfg(3, 0, 1);
        bus_write(1, 8'h01);
        push_play(3, 0, 1, 2);
        drain("single");

        // Two passes with a 3-cycle gap; a second START mid-run is ignored.
        set_cfg(2, 3, 2);
        bus_write(1, 8'h01);
        push_play(2, 3, 2, 3);
        fork
            drain("gap");
            begin
                repeat (3) @(negedge clk);
                bus_write(1, 8'h01);
            end
        join

        // Continuous playback, stopped by soft reset.
        set_cfg(2, 0, 0);
        bus_write(1, 8'h01);
        push_play(2, 0, 4, 0);
        drain("forever");
        bus_write(0, 8'h00);
        check("srst_seq_out", {16'd0, seq_out}, 32'd0);
        check("srst_seq_active", {31'd0, seq_active}, 32'd0);
        read_check("srst_ready", 1, 8'h01);
        read_check("srst_size", 3, 8'h00);

        // External start: three cycles later than a bus START.
        set_cfg(2, 0, 1);
        bus_write(2, 8'h01);
        ext = 1'b1;
        @(negedge clk);
        ext = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(16'h0, 1'b0);
        push_play(2, 0, 1, 2);
        drain("ext_en");

        bus_write(2, 8'h00);
        ext = 1'b1;
        @(negedge clk);
        ext = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(16'h0, 1'b0);
        drain("ext_dis");

        // Little-endian byte lanes form the 16-bit word.
        mem_write_word(0, 16'h1234);
        set_cfg(1, 0, 1);
        bus_write(1, 8'h01);
        push_play(1, 0, 1, 2);
        drain("lanes");

        // SIZE=0 never leaves IDLE.
        set_cfg(0, 0, 1);
        bus_write(1, 8'h01);
        for (int i = 0; i < 5; i++) push_exp(16'h0, 1'b0);
        drain("size0");
        read_check("size0_ready", 1, 8'h01);

        // Oversized SIZE plays the whole memory once.
        for (int k = 0; k < DEPTH; k++) mem_write_word(k, 16'(16'h5a00 + k));
        set_cfg(DEPTH + 5, 0, 1);
        bus_write(1, 8'h01);
        push_play(DEPTH, 0, 1, 2);
        drain("clamp");

        // START immediately followed by soft reset: nothing plays.
        set_cfg(2, 0, 1);
        bus_write(1, 8'h01);
        bus_write(0, 8'h00);
        for (int i = 0; i < 5; i++) push_exp(16'h0, 1'b0);
        drain("start_srst");
        read_check("start_srst_ready", 1, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
